// File: rtl/pipibibs_shram_pkg.sv
// Shared-RAM arbiter common types.
// State encoding, grant ids and default bus widths.
package pipibibs_shram_pkg;

  localparam int SHRAM_AW = 11;
  localparam int SHRAM_DW = 8;

  localparam logic GRANT_68K = 1'b0;
  localparam logic GRANT_Z80 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAITD,
    DONE
  } state_e;

endpackage

// File: rtl/pipibibs_rr_arb2.sv
// Two-input round-robin picker.
// Holds last_grant; a tie goes to the other side.
module pipibibs_rr_arb2
  import pipibibs_shram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_id_o,
  output logic       gnt_vld_o
);

  logic last_q;

  // Pick a winner; on a tie favour whoever did not win last.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_id_o  = GRANT_68K;
    if (&req_i) begin
      gnt_id_o = ~last_q;
    end else if (req_i[1]) begin
      gnt_id_o = GRANT_Z80;
    end
  end

  // Remember the winner of each accepted grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= GRANT_Z80;
    end else if (advance_i && gnt_vld_o) begin
      last_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/pipibibs_shram_arbiter.sv
// 68K / Z80 sound shared-RAM arbiter.
// One BRAM access at a time; Z80 is stalled via WAIT.
module pipibibs_shram_arbiter
  import pipibibs_shram_pkg::*;
#(
  parameter int AW      = SHRAM_AW,
  parameter int DW      = SHRAM_DW,
  parameter int RAM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          M68K_REQ,
  input  logic [AW-1:0] M68K_ADDR,
  input  logic          M68K_WE,
  input  logic [DW-1:0] M68K_DIN,
  output logic [DW-1:0] M68K_DOUT,
  output logic          M68K_ACK,
  input  logic          Z80_REQ,
  input  logic [AW-1:0] Z80_ADDR,
  input  logic          Z80_WE,
  input  logic [DW-1:0] Z80_DIN,
  output logic [DW-1:0] Z80_DOUT,
  output logic          Z80_ACK,
  output logic          Z80_WAIT,
  output logic [AW-1:0] RAM_ADDR,
  output logic          RAM_WE,
  output logic [DW-1:0] RAM_DIN,
  input  logic [DW-1:0] RAM_DOUT
);

  localparam logic [1:0] WAIT_LOAD = 2'(RAM_LAT - 1);

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic          we_q;
  logic          owner_q;
  logic          m_ack_q;
  logic          z_ack_q;
  logic          ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;
  logic [DW-1:0] m_dout_q;
  logic [DW-1:0] z_dout_q;

  logic [1:0]    req;
  logic          gnt_id;
  logic          gnt_vld;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;

  // A requester showing its ACK may still hold REQ; it sits out.
  assign req = {Z80_REQ & ~z_ack_q, M68K_REQ & ~m_ack_q};

  pipibibs_rr_arb2 u_arb (
    .clk_i     (CLK),
    .rst_ni    (RESET_N),
    .req_i     (req),
    .advance_i (state_q == IDLE),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (gnt_vld)
  );

  assign sel_addr = (gnt_id == GRANT_Z80) ? Z80_ADDR : M68K_ADDR;
  assign sel_din  = (gnt_id == GRANT_Z80) ? Z80_DIN  : M68K_DIN;
  assign sel_we   = (gnt_id == GRANT_Z80) ? Z80_WE   : M68K_WE;

  // Access sequencer: grant, strobe, wait out latency, complete.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      owner_q    <= GRANT_68K;
      m_ack_q    <= 1'b0;
      z_ack_q    <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      m_dout_q   <= '0;
      z_dout_q   <= '0;
    end else begin
      m_ack_q  <= 1'b0;
      z_ack_q  <= 1'b0;
      ram_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            owner_q    <= gnt_id;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
            we_q       <= sel_we;
            ram_we_q   <= sel_we;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (RAM_LAT == 1) begin
            state_q <= DONE;
          end else begin
            cnt_q   <= WAIT_LOAD;
            state_q <= WAITD;
          end
        end
        WAITD: begin
          if (cnt_q == 2'd1) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          if (!we_q) begin
            if (owner_q == GRANT_Z80) begin
              z_dout_q <= RAM_DOUT;
            end else begin
              m_dout_q <= RAM_DOUT;
            end
          end
          m_ack_q <= (owner_q == GRANT_68K);
          z_ack_q <= (owner_q == GRANT_Z80);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M68K_DOUT = m_dout_q;
  assign M68K_ACK  = m_ack_q;
  assign Z80_DOUT  = z_dout_q;
  assign Z80_ACK   = z_ack_q;
  assign Z80_WAIT  = Z80_REQ & ~z_ack_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WE    = ram_we_q;
  assign RAM_DIN   = ram_din_q;

endmodule

// File: tb/tb_pipibibs_shram_arbiter.sv
// Bench for the shared-RAM arbiter.
// Two instances: RAM_LAT=1 (idx 0/1) and RAM_LAT=3 (idx 2/3).
module tb_pipibibs_shram_arbiter;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       chk;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;
  exp_t sbq[4][$];
  int ackcnt[4] = '{0, 0, 0, 0};
  int order[$];
  int wecnt1 = 0;
  int we_cyc1 = -1;

  // instance 1 (RAM_LAT = 1)
  logic m1_req = 0, m1_we = 0, z1_req = 0, z1_we = 0;
  logic [10:0] m1_addr = 0, z1_addr = 0, r1_addr;
  logic [7:0] m1_din = 0, z1_din = 0, m1_dout, z1_dout;
  logic [7:0] r1_din, r1_dout;
  logic m1_ack, z1_ack, z1_wait, r1_we;

  // instance 3 (RAM_LAT = 3)
  logic m3_req = 0, m3_we = 0, z3_req = 0, z3_we = 0;
  logic [10:0] m3_addr = 0, z3_addr = 0, r3_addr;
  logic [7:0] m3_din = 0, z3_din = 0, m3_dout, z3_dout;
  logic [7:0] r3_din, r3_dout;
  logic m3_ack, z3_ack, z3_wait, r3_we;

  pipibibs_shram_arbiter #(.AW(11), .DW(8), .RAM_LAT(1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N),
    .M68K_REQ(m1_req), .M68K_ADDR(m1_addr), .M68K_WE(m1_we),
    .M68K_DIN(m1_din), .M68K_DOUT(m1_dout), .M68K_ACK(m1_ack),
    .Z80_REQ(z1_req), .Z80_ADDR(z1_addr), .Z80_WE(z1_we),
    .Z80_DIN(z1_din), .Z80_DOUT(z1_dout), .Z80_ACK(z1_ack),
    .Z80_WAIT(z1_wait), .RAM_ADDR(r1_addr), .RAM_WE(r1_we),
    .RAM_DIN(r1_din), .RAM_DOUT(r1_dout)
  );

  pipibibs_shram_arbiter #(.AW(11), .DW(8), .RAM_LAT(3)) dut3 (
    .CLK(CLK), .RESET_N(RESET_N),
    .M68K_REQ(m3_req), .M68K_ADDR(m3_addr), .M68K_WE(m3_we),
    .M68K_DIN(m3_din), .M68K_DOUT(m3_dout), .M68K_ACK(m3_ack),
    .Z80_REQ(z3_req), .Z80_ADDR(z3_addr), .Z80_WE(z3_we),
    .Z80_DIN(z3_din), .Z80_DOUT(z3_dout), .Z80_ACK(z3_ack),
    .Z80_WAIT(z3_wait), .RAM_ADDR(r3_addr), .RAM_WE(r3_we),
    .RAM_DIN(r3_din), .RAM_DOUT(r3_dout)
  );

  function automatic logic [7:0] pat(input logic [10:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // BRAM models with 1 and 3 cycle read latency
  logic [7:0] mem1 [2048];
  logic [7:0] mem3 [2048];
  logic [7:0] p1, p3a, p3b, p3c;
  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem1[i] <= pat(11'(i));
      mem3[i] <= pat(11'(i));
    end
  end
  always @(posedge CLK) begin
    if (r1_we) mem1[r1_addr] <= r1_din;
    p1 <= mem1[r1_addr];
    if (r3_we) mem3[r3_addr] <= r3_din;
    p3a <= mem3[r3_addr];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign r1_dout = p1;
  assign r3_dout = p3c;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input int c,
                      input logic [7:0] d, input logic k);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    e.chk  = k;
    sbq[idx].push_back(e);
  endtask

  task automatic chk_ack(input int idx, input logic ack,
                         input logic [7:0] dout);
    exp_t e;
    if (ack) begin
      ackcnt[idx]++;
      if (idx < 2) order.push_back(idx);
      check($sformatf("ack_expected[%0d]", idx),
            32'(sbq[idx].size() != 0), 1);
      if (sbq[idx].size() != 0) begin
        e = sbq[idx].pop_front();
        check($sformatf("ack_cycle[%0d]", idx), e.cyc, cyc);
        if (e.chk)
          check($sformatf("dout[%0d]", idx), dout, e.data);
      end
    end
  endtask

  // Scoreboard side: every ACK pops and checks an expectation
  always @(negedge CLK) begin
    chk_ack(0, m1_ack, m1_dout);
    chk_ack(1, z1_ack, z1_dout);
    chk_ack(2, m3_ack, m3_dout);
    chk_ack(3, z3_ack, z3_dout);
    if (r1_we) begin
      wecnt1++;
      we_cyc1 = cyc;
    end
  end

  task automatic wait_ack(input int idx, input int budget);
    int s = ackcnt[idx];
    int n = 0;
    while (ackcnt[idx] == s && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check($sformatf("ack_arrived[%0d]", idx),
          32'(ackcnt[idx] != s), 1);
  endtask

  initial begin
    int t0;
    int w0;
    int a0;
    // reset state
    z1_req = 1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_m_ack", m1_ack, 0);
    check("rst_z_ack", z1_ack, 0);
    check("rst_ram_we", r1_we, 0);
    check("rst_ram_addr", r1_addr, 0);
    check("rst_ram_din", r1_din, 0);
    check("rst_m_dout", m1_dout, 0);
    check("rst_z_dout", z1_dout, 0);
    check("rst_wait_follows", z1_wait, 1);
    z1_req = 0;
    #1;
    check("rst_wait_low", z1_wait, 0);
    @(negedge CLK);
    RESET_N = 1;

    // 68K write 0x012=A5, REQ held through ACK cycle
    @(negedge CLK);
    t0 = cyc;
    w0 = wecnt1;
    m1_req = 1; m1_addr = 11'h012; m1_we = 1; m1_din = 8'hA5;
    push(0, t0 + 3, 8'h00, 0);
    wait_ack(0, 10);
    @(posedge CLK);
    #1;
    m1_req = 0;
    repeat (4) @(negedge CLK);
    #1;
    check("we_count", wecnt1, w0 + 1);
    check("we_cycle", we_cyc1, t0 + 1);

    // 68K read back 0x012
    @(negedge CLK);
    t0 = cyc;
    m1_req = 1; m1_we = 0; m1_din = 8'h00;
    push(0, t0 + 3, 8'hA5, 1);
    wait_ack(0, 10);
    m1_req = 0;
    repeat (2) @(negedge CLK);
    #1;
    check("m_dout_held", m1_dout, 8'hA5);
    check("no_we_on_read", wecnt1, w0 + 1);

    // reset pulse so the tie starts from last_grant = Z80
    @(negedge CLK);
    RESET_N = 0;
    @(negedge CLK);
    RESET_N = 1;

    // simultaneous first requests
    @(negedge CLK);
    t0 = cyc;
    m1_req = 1; m1_addr = 11'h7FF; m1_we = 0;
    z1_req = 1; z1_addr = 11'h000; z1_we = 0;
    push(0, t0 + 3, pat(11'h7FF), 1);
    push(1, t0 + 6, pat(11'h000), 1);
    #1;
    check("wait_c0", z1_wait, 1);
    repeat (3) @(negedge CLK);
    #1;
    check("wait_c3", z1_wait, 1);
    m1_req = 0;
    repeat (2) @(negedge CLK);
    #1;
    check("wait_c5", z1_wait, 1);
    @(negedge CLK);
    #1;
    check("wait_c6", z1_wait, 0);
    z1_req = 0;
    repeat (2) @(negedge CLK);

    // continuous contention, 8 accesses
    order.delete();
    @(negedge CLK);
    t0 = cyc;
    m1_req = 1; m1_addr = 11'h012;
    z1_req = 1; z1_addr = 11'h001;
    for (int i = 0; i < 4; i++) begin
      push(0, t0 + 3 + 6 * i, 8'hA5, 1);
      push(1, t0 + 6 + 6 * i, pat(11'h001), 1);
    end
    repeat (21) @(negedge CLK);
    #1;
    m1_req = 0;
    repeat (3) @(negedge CLK);
    #1;
    z1_req = 0;
    repeat (3) @(negedge CLK);
    check("order_len", order.size(), 8);
    for (int i = 0; i < order.size(); i++)
      check($sformatf("order[%0d]", i), order[i], i % 2);

    // RAM_LAT=3: write 0x155=3C, then Z80 reads it
    @(negedge CLK);
    t0 = cyc;
    m3_req = 1; m3_addr = 11'h155; m3_we = 1; m3_din = 8'h3C;
    push(2, t0 + 5, 8'h00, 0);
    wait_ack(2, 12);
    m3_req = 0; m3_we = 0;
    @(negedge CLK);
    t0 = cyc;
    z3_req = 1; z3_addr = 11'h155; z3_we = 0;
    push(3, t0 + 5, 8'h3C, 1);
    wait_ack(3, 12);
    z3_req = 0;
    @(negedge CLK);
    #1;
    check("z3_dout_held", z3_dout, 8'h3C);

    // reset pulse while a Z80 read sits in WAITD
    @(negedge CLK);
    a0 = ackcnt[3];
    z3_req = 1; z3_addr = 11'h000;
    repeat (2) @(negedge CLK);
    #1;
    RESET_N = 0;
    #1;
    check("rst_mid_we", r3_we, 0);
    check("rst_mid_ack", z3_ack, 0);
    check("rst_mid_wait", z3_wait, 1);
    z3_req = 0;
    @(negedge CLK);
    RESET_N = 1;
    repeat (8) @(negedge CLK);
    #1;
    check("no_ack_after_rst", ackcnt[3], a0);

    // fresh 68K requests after reset release
    @(negedge CLK);
    t0 = cyc;
    m1_req = 1; m1_addr = 11'h012; m1_we = 0;
    m3_req = 1; m3_addr = 11'h155; m3_we = 0;
    push(0, t0 + 3, 8'hA5, 1);
    push(2, t0 + 5, 8'h3C, 1);
    wait_ack(0, 10);
    m1_req = 0;
    wait_ack(2, 10);
    m3_req = 0;
    repeat (3) @(negedge CLK);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("sb_empty[%0d]", i), sbq[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipibibs_shram_arbiter.md
Name: pipibibs_shram_arbiter

Overview:
- Serialises 68K and Z80 accesses to the single-port 2 KB x 8 sound shared RAM, which both CPUs use for command and status exchange.
- Sits between the 68K bus decode in the CPU block, the Z80 memory decode in the sound block, and the BRAM that holds the shared RAM.
- Grants one access at a time, with round-robin on ties, and stalls the Z80 through a wait output until its access completes.

Parameters:
- AW, 11, shared RAM address width.
- DW, 8, shared RAM data width.
- RAM_LAT, 1, read latency of RAM_DOUT in CLK cycles after RAM_ADDR is presented. Legal range 1..3.

Ports:
- CLK  in  1  47.25 MHz system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- M68K_REQ  in  1  68K access request. Level; held until M68K_ACK.
- M68K_ADDR  in  AW  68K byte address.
- M68K_WE  in  1  1 = write, 0 = read.
- M68K_DIN  in  DW  68K write data.
- M68K_DOUT  out  DW  68K read data. Valid in the M68K_ACK cycle and held afterwards.
- M68K_ACK  out  1  one-cycle completion pulse.
- Z80_REQ  in  1  Z80 access request. Level; held until Z80_ACK.
- Z80_ADDR  in  AW  Z80 address.
- Z80_WE  in  1  1 = write, 0 = read.
- Z80_DIN  in  DW  Z80 write data.
- Z80_DOUT  out  DW  Z80 read data. Valid in the Z80_ACK cycle and held afterwards.
- Z80_ACK  out  1  one-cycle completion pulse.
- Z80_WAIT  out  1  Z80 wait request.
- RAM_ADDR  out  AW  address to the BRAM.
- RAM_WE  out  1  BRAM write strobe.
- RAM_DIN  out  DW  BRAM write data.
- RAM_DOUT  in  DW  BRAM read data.

Behaviour:
- Clocking and reset: single clock domain (CLK). RESET_N is asynchronous and active-low. All state is in flops cleared by RESET_N.
- Reset values:
  - state = IDLE.
  - M68K_ACK, Z80_ACK, RAM_WE = 0.
  - RAM_ADDR, RAM_DIN, M68K_DOUT, Z80_DOUT = 0.
  - last_grant = Z80, so the 68K wins the first tie.
- State machine (IDLE, ACCESS, WAITD, DONE):
  - IDLE: sample the eligible requests.
    - If only one is eligible, grant it.
    - If both are eligible, grant the requester that is not last_grant.
    - On a grant: register the granted ADDR/DIN into RAM_ADDR/RAM_DIN, register WE into an internal we flag, set last_grant, go to ACCESS.
  - ACCESS (exactly 1 cycle): RAM_WE = we flag; RAM_ADDR and RAM_DIN are stable.
    - RAM_LAT = 1: go to DONE.
    - Otherwise: go to WAITD and load a down-counter with RAM_LAT-1.
  - WAITD: RAM_WE = 0, address held. Decrement the counter; go to DONE when it reaches 1.
  - DONE (1 cycle): capture RAM_DOUT into the granted requester's DOUT register (reads only; writes leave DOUT unchanged). Assert that requester's ACK in the next cycle, then return to IDLE.
- Timing:
  - ACK is registered. It asserts in the cycle in which the state machine re-enters IDLE.
  - Uncontended latency: request sampled in IDLE at cycle 0, ACK high in cycle 2+RAM_LAT. That is cycle 3 for the default.
  - RAM_WE is high for exactly one cycle per write, in ACCESS.
  - No RAM access is issued during IDLE.
- Eligibility:
  - A requester whose ACK is high in the current cycle is not eligible in that cycle, because its REQ may still be high. This prevents a double access.
  - The other requester may be granted in that same cycle. There is no idle bubble between back-to-back grants to different requesters.
- Z80_WAIT:
  - Combinational: Z80_REQ & ~Z80_ACK.
  - While RESET_N is low it follows Z80_REQ; the Z80 is itself held in reset then.
- Input stability: request inputs are sampled only at the grant cycle. Changes to ADDR/DIN/WE after the grant are ignored.
- Request withdrawn before grant: no access is issued and no ACK is produced.
- Simultaneous requests: strict alternation. A requester continuously requesting back-to-back gets at most every other grant.
- Worst-case wait (other requester granted first): 2*(2+RAM_LAT) cycles.
- Reset asserted mid-operation: RAM_WE drops asynchronously, the in-flight access is abandoned, no ACK is issued after reset release, and last_grant returns to Z80.

Decomposition:
- Shared package pipibibs_shram_pkg holds:
  - the state enum (IDLE, ACCESS, WAITD, DONE);
  - the grant id constants GRANT_68K = 1'b0 and GRANT_Z80 = 1'b1;
  - the default AW/DW localparams.
- One sub-module is natural: pipibibs_rr_arb2. It is a two-input round-robin picker containing the last_grant flop, with inputs req[1:0] and advance, and output grant id plus grant valid.

Test Plan:
- 68K write then read, uncontended: 68K write A=0x012, D=0xA5; RAM_WE high exactly in cycle 1; ACK in cycle 3. Then read 0x012: M68K_DOUT = 0xA5 with ACK in cycle 3.
- Simultaneous first requests from reset: 68K read 0x7FF, Z80 read 0x000. 68K is granted first (ACK in cycle 3); Z80 is granted in cycle 3 with its ACK in cycle 6; Z80_WAIT is high for cycles 0..5.
- Continuous contention over 8 accesses: grants strictly alternate 68K, Z80, 68K, …; no requester gets two grants in a row while the other is requesting.
- RAM_LAT=3 build: Z80 read of 0x155 preloaded with 0x3C gives ACK in cycle 5 with Z80_DOUT = 0x3C.
- Reset pulse in WAITD during a Z80 read: RAM_WE = 0 and no Z80_ACK after release. After release, a new 68K request completes with the normal 3-cycle latency.
- REQ held high through the ACK cycle: no second access is issued, and the RAM write count stays 1 for a single write request.
